enc8to3_pri_hs: RTL

- Registered 8-to-3 priority encoder with request latching and a valid/ack handshake. It is the encode-side counterpart of the team's 3-to-8 decoder.
- Latches up to 8 request lines, grants one at a time, and presents the granted index on A/B/C (A = LSB, same bit order as the decoder inputs).
- Holds each grant stable until the consumer acknowledges it.
- Sits between peripheral request lines and the decoder/service logic.

---
 rtl/enc8to3_pri_hs.sv | 113 +++++++++++
 1 files changed

// File: rtl/enc8to3_pri_hs.sv
// Registered 8-to-3 priority encoder with request latching and valid/ack handshake.
// Optional round-robin arbitration when ENC_ROUND_ROBIN_EN is defined.
module enc8to3_pri_hs #(
  parameter bit HI_FIRST = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       G,
  input  logic [7:0] I,
  input  logic       ACK,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       VALID,
  output logic [7:0] PEND
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state, state_next;
  logic [2:0] idx, idx_next, grant_idx;
  logic [7:0] clr, pend_next;
  logic       ack_fire;

`ifdef ENC_ROUND_ROBIN_EN
  logic [2:0] last, scan_base;

  function automatic logic [2:0] rr_encode(input logic [7:0] p, input logic [2:0] base);
    logic       found;
    logic [2:0] j;
    rr_encode = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      j = 3'(base + 3'd1 + 3'(k));
      if (!found && p[j]) begin
        rr_encode = j;
        found     = 1'b1;
      end
    end
  endfunction

  // On an ACK edge the pointer moves to the current grant, so the back-to-back
  // grant must already scan from the index being acknowledged.
  always_comb begin
    scan_base = ack_fire ? idx : last;
    grant_idx = rr_encode(pend_next, scan_base);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N)        last <= '0;
    else if (ack_fire) last <= idx;
  end
`else
  function automatic logic [2:0] pri_encode(input logic [7:0] p);
    pri_encode = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (HI_FIRST) begin
        if (p[3'(i)]) pri_encode = 3'(i);
      end else begin
        if (p[3'(7 - i)]) pri_encode = 3'(7 - i);
      end
    end
  endfunction

  always_comb grant_idx = pri_encode(pend_next);
`endif

  always_comb begin
    ack_fire = (state == GRANT) && ACK;
    clr      = '0;
    if (ack_fire) clr[idx] = 1'b1;
    pend_next = (PEND & ~clr) | (G ? 8'h00 : I);

    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (!G && pend_next != '0) begin
          state_next = GRANT;
          idx_next   = grant_idx;
        end
      end
      GRANT: begin
        if (ACK) begin
          if (!G && pend_next != '0) idx_next   = grant_idx;
          else                       state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      idx   <= '0;
      PEND  <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      PEND  <= pend_next;
    end
  end

  assign A     = idx[0];
  assign B     = idx[1];
  assign C     = idx[2];
  assign VALID = (state == GRANT);

endmodule
